fsrc_sysref_gen: RTL
====================

// Module: fsrc_sysref_gen
// PURPOSE
//  Upstream of the TX FSRC sequencer: derives the internal SYSREF pulse (sysref_int) that the sequencer counts.
//  Synchronises external SYSREF, then qualifies its period against a programmed value.
//  Once LOCK_COUNT consecutive on-time edges are seen, emits a free-running 1-cycle pulse every `period` clocks.
//  The pulse stays phase-aligned to the external edges and tolerates gapped or one-shot SYSREF once locked.
// PARAMETERS
//  PERIOD_WIDTH  16  width of period and phase counter
//  LOCK_COUNT    4   consecutive on-time edges required to lock (>=1)
//  SYNC_STAGES   2   synchroniser flops on sysref_ext (>=2)
// PORTS
//  clk         in   1             core clock; single clock domain
//  resetn      in   1             asynchronous, active-low reset
//  sysref_ext  in   1             external SYSREF level, asynchronous to clk
//  enable      in   1             1 = acquire/run, 0 = return to IDLE
//  period      in   PERIOD_WIDTH  clk cycles between SYSREF edges (>=2)
//  err_clr     in   1             1-cycle pulse, clears sticky errors
//  sysref_int  out  1             1-cycle aligned internal SYSREF pulse (valid only when locked)
//  locked      out  1             1 while state == LOCKED
//  period_err  out  1             sticky: misaligned edge seen while LOCKED
//  cfg_err     out  1             sticky: enable asserted with period < 2
// BEHAVIOUR
//  Reset: all flops incl. synchroniser cleared.
//   - sysref_int=0, locked=0, period_err=0, cfg_err=0, state=IDLE.
//  Edge detect: re = sync_out & ~sync_out_d; re is valid SYNC_STAGES+1 cycles after the sysref_ext transition.
//  Phase counter p: p <= (p == period_q-1) ? 0 : p+1; any re in ACQUIRE or LOCKED forces p <= 0.
//   - "On time" means re arrives in a cycle where p == period_q-1.
//  FSM:
//   - IDLE: p, match_cnt, armed = 0. On enable & period>=2: latch period_q <= period, go to ACQUIRE.
//     On enable & period<2: set cfg_err, stay in IDLE.
//   - ACQUIRE: first re sets armed=1.
//     Each later re: on time -> match_cnt+1; else match_cnt <= 0.
//     When match_cnt reaches LOCK_COUNT (on the re that hits it) -> LOCKED.
//   - LOCKED: p free-runs. sysref_int <= (p == period_q-1), i.e. the pulse is high in the cycle where p == 0.
//     No re = normal, keep pulsing. On-time re = no action.
//     Off-time re -> period_err <= 1, match_cnt <= 0, armed <= 1, p <= 0, go to ACQUIRE.
//  Pulse timing:
//   - Lock pulse: sysref_int is first high 1 cycle after the locking re.
//   - Steady state: consecutive pulses are exactly period_q cycles apart.
//   - sysref_int is 0 in IDLE and ACQUIRE.
//  enable=0 in any state -> IDLE next cycle; locked and sysref_int drop that cycle. Sticky errors are kept.
//  period changes are ignored until the next IDLE->ACQUIRE; period_q is the only period used.
//  Errors: err_clr clears period_err and cfg_err. An error set in the same cycle as err_clr wins (stays 1).
//  match_cnt saturates at LOCK_COUNT. p is compared with equality only; no overflow is possible because period_q <= 2^PERIOD_WIDTH-1.
//  Async reset mid-LOCKED: immediate return to reset values; after release, re-acquisition is required.
// STRUCTURE
//  fsrc_pkg:
//   - typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} sysref_gen_state_t.
//   - localparam MIN_SYSREF_PERIOD = 2.
//  Sub-module fsrc_sync_bits: parameterised N-stage synchroniser with async active-low reset.
//  Remainder in one file: edge detect, phase counter, FSM, status regs.
// TESTING
//  T1: period=8, edges every 8 clks.
//      -> locked asserts on the 5th edge (4 matches); sysref_int then every 8 clks, 1 cycle after each re.
//  T2: locked, then one edge arrives 9 clks after the previous.
//      -> period_err=1, locked=0 and sysref_int stops; relocks after 4 more on-time edges; period_err stays 1 until err_clr.
//  T3: locked, then sysref_ext held low for 100 clks.
//      -> sysref_int keeps pulsing every 8 clks; locked stays 1.
//  T4: enable=1 with period=1.
//      -> cfg_err=1, state stays IDLE, no sysref_int.
//      Then period=8 and enable toggled -> normal lock.
//  T5: resetn pulsed low while locked.
//      -> all outputs 0 the same cycle.
//      enable dropped while locked -> locked=0 next cycle.
//      period changed to 12 while locked -> pulse spacing stays 8.
//  T6: err_clr in the same cycle as an off-time re -> period_err remains 1.

Source files
------------

// File: rtl/fsrc_pkg.sv
// fsrc_pkg: shared types and constants for the FSRC SYSREF generator.
package fsrc_pkg;
   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} sysref_gen_state_t;
   localparam int MIN_SYSREF_PERIOD = 2;
endpackage

// File: rtl/fsrc_sysref_gen_if.sv
// fsrc_sysref_gen_if: control, SYSREF and status signals of the SYSREF generator.
interface fsrc_sysref_gen_if #(parameter int PERIOD_WIDTH = 16) ();
   logic                    sysref_ext;
   logic                    enable;
   logic [PERIOD_WIDTH-1:0] period;
   logic                    err_clr;
   logic                    sysref_int;
   logic                    locked;
   logic                    period_err;
   logic                    cfg_err;
   modport master (output sysref_ext, enable, period, err_clr, input sysref_int, locked, period_err, cfg_err);
   modport slave (input sysref_ext, enable, period, err_clr, output sysref_int, locked, period_err, cfg_err);
endinterface

// File: rtl/fsrc_sync_bits.sv
// fsrc_sync_bits: N-stage synchroniser with asynchronous active-low reset.
module fsrc_sync_bits #(parameter int N = 2) (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic q_o
);
   logic [N-1:0] sync_q;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) sync_q <= '0;
      else sync_q <= {sync_q[N-2:0], d_i};
   assign q_o = sync_q[N-1];
endmodule

// File: rtl/fsrc_sysref_gen.sv
// fsrc_sysref_gen: qualifies external SYSREF against a programmed period and
// emits a phase-aligned free-running internal SYSREF pulse once locked.
module fsrc_sysref_gen
   import fsrc_pkg::*;
#(
   parameter int PERIOD_WIDTH = 16,
   parameter int LOCK_COUNT   = 4,
   parameter int SYNC_STAGES  = 2
) (
   input logic clk,
   input logic resetn,
   fsrc_sysref_gen_if.slave bus
);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam logic [MW-1:0] LC = MW'(LOCK_COUNT);
   sysref_gen_state_t state_q;
   logic [PERIOD_WIDTH-1:0] p_q, p_d, period_q;
   logic [MW-1:0] match_q;
   logic sync_out, sync_d_q, re, p_last;
   logic armed_q, sysref_int_q, locked_q, period_err_q, cfg_err_q;
   fsrc_sync_bits #(.N(SYNC_STAGES)) u_sync (.clk(clk), .resetn(resetn), .d_i(bus.sysref_ext), .q_o(sync_out));
   assign re     = sync_out & ~sync_d_q;
   assign p_last = p_q == period_q - 1'b1;
   assign p_d    = (re || p_last) ? '0 : p_q + 1'b1;
   // Error sets are written after the clear so a same-cycle set wins.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q      <= IDLE;
         p_q          <= '0;
         period_q     <= '0;
         match_q      <= '0;
         sync_d_q     <= 1'b0;
         armed_q      <= 1'b0;
         sysref_int_q <= 1'b0;
         locked_q     <= 1'b0;
         period_err_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         sync_d_q     <= sync_out;
         period_err_q <= period_err_q & ~bus.err_clr;
         cfg_err_q    <= cfg_err_q & ~bus.err_clr;
         if (!bus.enable) begin
            state_q      <= IDLE;
            p_q          <= '0;
            match_q      <= '0;
            armed_q      <= 1'b0;
            sysref_int_q <= 1'b0;
            locked_q     <= 1'b0;
         end else
            case (state_q)
               IDLE:
                  if (bus.period >= PERIOD_WIDTH'(MIN_SYSREF_PERIOD)) begin
                     period_q <= bus.period;
                     state_q  <= ACQUIRE;
                  end else cfg_err_q <= 1'b1;
               ACQUIRE: begin
                  p_q <= p_d;
                  if (re) begin
                     armed_q <= 1'b1;
                     match_q <= (armed_q && p_last) ? match_q + 1'b1 : '0;
                     if (armed_q && p_last && match_q == LC - 1'b1) begin
                        state_q      <= LOCKED;
                        locked_q     <= 1'b1;
                        sysref_int_q <= 1'b1;
                     end
                  end
               end
               LOCKED:
                  if (re && !p_last) begin
                     period_err_q <= 1'b1;
                     match_q      <= '0;
                     armed_q      <= 1'b1;
                     p_q          <= '0;
                     state_q      <= ACQUIRE;
                     locked_q     <= 1'b0;
                     sysref_int_q <= 1'b0;
                  end else begin
                     p_q          <= p_d;
                     sysref_int_q <= p_last;
                  end
               default: state_q <= IDLE;
            endcase
      end
   assign bus.sysref_int = sysref_int_q;
   assign bus.locked     = locked_q;
   assign bus.period_err = period_err_q;
   assign bus.cfg_err    = cfg_err_q;
endmodule
